reg_file: RTL
=============

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameters: none; widths come from the shared package (XLEN = 32, REG_ADDR_W = 5, NUM_REGS = 32).
REQ-002 Ports SHALL be, in this order:
- clk  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- rs1_addr  input  5  read port 1 register index.
- rs2_addr  input  5  read port 2 register index.
- rd_addr  input  5  write port register index.
- rd_data  input  32  write data.
- rd_wren  input  1  write enable, sampled on the rising clk edge.
- rs1_data  output  32  read port 1 data.
- rs2_data  output  32  read port 2 data.

Function
REQ-003 Storage SHALL be 32 registers x 32 bits, x1..x31 physically held; x0 SHALL NOT be stored.
REQ-004 Write: on a rising clk edge with rd_wren=1 and rd_addr!=0, register[rd_addr] SHALL take rd_data; latency 1 cycle.
REQ-005 A write with rd_addr=0 SHALL be discarded with no side effect on any register.
REQ-006 A write with rd_wren=0 SHALL leave all registers unchanged regardless of rd_addr and rd_data.
REQ-007 Reads SHALL be combinational, with 0-cycle latency: rsN_data = register[rsN_addr].
REQ-008 A read of address 0 SHALL return 32'h0000_0000 on both ports, including during a write to address 0.
REQ-009 Both read ports SHALL be independent; rs1_addr = rs2_addr SHALL return identical data on both ports.
REQ-010 Same-cycle read/write of one nonzero address SHALL follow REQ-015/REQ-016.
REQ-011 Outputs SHALL contain no X: every address 0..31 is valid; there is no out-of-range case.

Reset
REQ-012 While reset=1, x1..x31 SHALL be cleared to 0 asynchronously, without waiting for clk.
REQ-013 While reset=1, writes SHALL be blocked.
REQ-014 While reset=1, rs1_data and rs2_data SHALL read 0 for every address.
- Reset asserted during a write edge: reset wins; the register stays 0.
- First write accepted: first rising clk edge after reset deasserts.

Configuration
REQ-015 With macro REGFILE_BYPASS_EN defined: when rd_wren=1, rd_addr!=0, reset=0 and rsN_addr=rd_addr, rsN_data SHALL equal rd_data in the same cycle (write-first forwarding).
REQ-016 Without REGFILE_BYPASS_EN: rsN_data SHALL return the pre-write register value in that cycle; the new value is visible from the next cycle.
REQ-017 Bypass SHALL never apply to address 0.

Structure
REQ-018 Shared package reg_file_pkg SHALL hold XLEN, REG_ADDR_W, NUM_REGS and typedef reg_addr_t (logic [4:0]).
REQ-019 The package SHALL also hold typedef xlen_t (logic [31:0]).
REQ-020 One sub-module reg_file_rdport (32:1 x 32-bit read select plus the optional bypass compare) SHALL be instantiated twice, once per read port.
REQ-021 Write-enable decode (5-to-32 one-hot) SHALL live in reg_file.

Verification
REQ-022 Reset and zero register:
- Reset pulse mid-cycle, then read all 32 addresses on both ports -> all 0.
- Write x0 = 32'hFFFF_FFFF with rd_wren=1, then read rs1_addr=0 -> 32'h0.
REQ-023 Write then read: x5 = 32'hDEAD_BEEF; next cycle rs1_addr=5, rs2_addr=5 -> both 32'hDEAD_BEEF; x6 still 0.
REQ-024 Disabled write: rd_wren=0, rd_addr=7, rd_data=32'h1234_5678 -> x7 unchanged (0).
REQ-025 Same-cycle read/write: x9 holds 32'h1; write x9 = 32'h2 with rs1_addr=9 -> same cycle 32'h2 with REGFILE_BYPASS_EN, 32'h1 without; next cycle 32'h2 in both builds.
REQ-026 Reset during write: assert reset coincident with a write of x3 = 32'hA5A5_A5A5 -> x3 reads 0 after reset.
REQ-027 Full sweep: write x1..x31 = 32'h100 + index, then read all pairs (i, 31-i) -> correct values, x0 = 0.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared widths and types for the register file.
// Optional macro REGFILE_BYPASS_EN (consumed by reg_file_rdport) enables write-first forwarding.
package reg_file_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

endpackage

// File: rtl/reg_file_rdport.sv
// One combinational read port: 32:1 select over the register view.
// With REGFILE_BYPASS_EN defined, a live write to the same index is forwarded (write-first).
module reg_file_rdport
    import reg_file_pkg::*;
(
    input  logic [NUM_REGS-1:0][XLEN-1:0] i_regs,
    input  logic [4:0]                    i_rs_addr,
    input  logic                          i_wr_live,
    input  logic [4:0]                    i_wr_addr,
    input  logic [31:0]                   i_wr_data,
    output logic [31:0]                   o_rs_data
);

`ifdef REGFILE_BYPASS_EN
    // i_wr_live already excludes x0 and reset, so forwarding never touches x0
    always_comb begin
        o_rs_data = i_regs[i_rs_addr];
        if (i_wr_live && (i_wr_addr == i_rs_addr))
            o_rs_data = i_wr_data;
    end
`else
    logic w_unused_wr;

    assign o_rs_data   = i_regs[i_rs_addr];
    assign w_unused_wr = ^{i_wr_live, i_wr_addr, i_wr_data};
`endif

endmodule

// File: rtl/reg_file.sv
// 32 x 32-bit register file, x0 hardwired to zero, two async read ports, one sync write port.
// Build option: REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding.
module reg_file
    import reg_file_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    input  logic        rd_wren,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data
);

    logic [NUM_REGS-1:1][XLEN-1:0] r_regs;
    logic [NUM_REGS-1:0][XLEN-1:0] w_regs_view;
    logic [NUM_REGS-1:1]           w_wr_sel;
    logic                          w_wr_live;

    assign w_wr_live = rd_wren & ~reset & (rd_addr != '0);

    always_comb begin
        w_wr_sel = '0;
        for (int i = 1; i < NUM_REGS; i++)
            w_wr_sel[i] = w_wr_live && (rd_addr == REG_ADDR_W'(i));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_regs <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++)
                if (w_wr_sel[i]) r_regs[i] <= rd_data;
        end
    end

    // x0 is not stored; the read view ties its slot to zero
    assign w_regs_view = {r_regs, XLEN'(0)};

    reg_file_rdport u_rdport1 (
        .i_regs    (w_regs_view),
        .i_rs_addr (rs1_addr),
        .i_wr_live (w_wr_live),
        .i_wr_addr (rd_addr),
        .i_wr_data (rd_data),
        .o_rs_data (rs1_data)
    );

    reg_file_rdport u_rdport2 (
        .i_regs    (w_regs_view),
        .i_rs_addr (rs2_addr),
        .i_wr_live (w_wr_live),
        .i_wr_addr (rd_addr),
        .i_wr_data (rd_data),
        .o_rs_data (rs2_data)
    );

endmodule
